// File: rtl/param_counter_pkg.sv
// rtl/param_counter_pkg.sv - shared constants and terminal-value helper for param_counter
package param_counter_pkg;

   localparam int   MAX_WIDTH = 32;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   // Count value at which a step wraps or, in one-shot mode, stops.
   function automatic logic [MAX_WIDTH-1:0] terminal_value(input logic dir,
                                                           input longint unsigned modulo);
      logic [MAX_WIDTH-1:0] t;
      if (dir == DIR_DOWN) t = '0;
      else                 t = MAX_WIDTH'(modulo - 64'd1);
      return t;
   endfunction

endpackage

// File: rtl/param_counter_prescaler.sv
// rtl/param_counter_prescaler.sv - enable divider: tick on every PRESCALE-th enabled cycle
module counter_prescaler
   import param_counter_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;
   logic          at_last;

   assign at_last = (phase_q == LAST);
   assign tick_o  = en_i & at_last;

   always_comb begin
      phase_d = phase_q;
      if (clr_i) begin
         phase_d = '0;
      end else if (en_i) begin
         phase_d = at_last ? '0 : phase_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/param_counter.sv
// rtl/param_counter.sv - modulo up/down counter with clear, load, terminal pulse and one-shot done
// Optional enable prescaler: define PARAM_COUNTER_PRESCALE_EN.
module param_counter
   import param_counter_pkg::*;
#(
   parameter int              WIDTH    = 8,
   parameter longint unsigned MODULO   = 256,
   parameter int              PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             oneshot,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);

   generate
      if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
         $error("param_counter: WIDTH out of range");
      end
      if (MODULO < 64'd2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
         $error("param_counter: MODULO out of range");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("param_counter: PRESCALE must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             done_q;
   logic             done_d;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] load_clamped;
   logic             at_term;
   logic             tick;
   logic             step;

   assign term         = WIDTH'(terminal_value(up_dn, MODULO));
   assign at_term      = (cnt_q == term);
   assign load_clamped = (64'(load_val) >= MODULO) ? MAX_VAL : load_val;

`ifdef PARAM_COUNTER_PRESCALE_EN
   // Prescaler is frozen while done so the phase survives until clr/load.
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en & ~done_q),
      .clr_i  (clr | load),
      .tick_o (tick)
   );
`else
   assign tick = en;
`endif

   assign step = tick & ~done_q;
   assign tc   = step & at_term & ~clr & ~load & ~rst;

   always_comb begin
      cnt_d  = cnt_q;
      done_d = done_q;
      if (clr) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (load) begin
         cnt_d  = load_clamped;
         done_d = 1'b0;
      end else if (step) begin
         if (!at_term) begin
            cnt_d = (up_dn == DIR_UP) ? cnt_q + 1'b1 : cnt_q - 1'b1;
         end else if (oneshot) begin
            done_d = 1'b1;
         end else begin
            cnt_d = (up_dn == DIR_UP) ? '0 : MAX_VAL;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = done_q;

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - vector table, corner sequences and random model check for param_counter
module tb_param_counter;

   localparam int WIDTH    = 8;
   localparam int MOD      = 10;
   localparam int PRESCALE = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             up_dn;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             oneshot;
   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             done;

   always #5 clk = ~clk;

   param_counter #(
      .WIDTH    (WIDTH),
      .MODULO   (MOD),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_dn    (up_dn),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .oneshot  (oneshot),
      .cnt      (cnt),
      .tc       (tc),
      .done     (done)
   );

   typedef struct {
      logic       en;
      logic       up_dn;
      logic       clr;
      logic       load;
      logic       oneshot;
      logic [7:0] load_val;
      logic       exp_tc;
      logic [7:0] exp_cnt;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   int   m_cnt  = 0;
   bit   m_done = 0;
   int   m_pre  = 0;

   function automatic vec_t mk(input logic e, input logic u, input logic c, input logic l,
                               input logic o, input int lv, input logic t, input int ec,
                               input logic ed);
      vec_t v;
      v.en = e; v.up_dn = u; v.clr = c; v.load = l; v.oneshot = o;
      v.load_val = 8'(lv); v.exp_tc = t; v.exp_cnt = 8'(ec); v.exp_done = ed;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      en = v.en; up_dn = v.up_dn; clr = v.clr; load = v.load;
      oneshot = v.oneshot; load_val = v.load_val;
      #1;
      check($sformatf("vec%0d_tc", idx), int'(tc), int'(v.exp_tc));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_cnt", idx), int'(cnt), int'(v.exp_cnt));
      check($sformatf("vec%0d_done", idx), int'(done), int'(v.exp_done));
   endtask

   // Reference: counts modulo MOD from the rules, one call per clock cycle.
   task automatic model_cycle(output bit exp_tc);
      int  term;
      bit  stp;
      term = up_dn ? MOD - 1 : 0;
`ifdef PARAM_COUNTER_PRESCALE_EN
      stp = en && !m_done && (m_pre == PRESCALE - 1);
`else
      stp = en && !m_done;
`endif
      exp_tc = stp && (m_cnt == term) && !clr && !load;
      if (clr) begin
         m_cnt = 0; m_done = 0; m_pre = 0;
      end else if (load) begin
         m_cnt = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
         m_done = 0; m_pre = 0;
      end else begin
         if (en && !m_done) m_pre = (m_pre + 1) % PRESCALE;
         if (stp) begin
            if (m_cnt == term && oneshot) m_done = 1;
            else m_cnt = (m_cnt + (up_dn ? 1 : MOD - 1)) % MOD;
         end
      end
   endtask

   initial begin
      bit exp_tc;

      rst = 1'b1; en = 1'b1; up_dn = 1'b0; clr = 1'b0; load = 1'b0;
      oneshot = 1'b0; load_val = '0;
      #3;
      check("rst_async_cnt", int'(cnt), 0);
      check("rst_async_done", int'(done), 0);
      check("rst_tc_gated", int'(tc), 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_held_cnt", int'(cnt), 0);
      @(negedge clk);
      en = 1'b0;
      #1;
      rst = 1'b0;

`ifndef PARAM_COUNTER_PRESCALE_EN
      for (int k = 0; k < 12; k++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, k == 9, (k + 1) % 10, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 200, 0, 9, 0));
      for (int k = 0; k < 11; k++) vecs.push_back(mk(1, 0, 0, 0, 0, 0, k == 9, (18 - k) % 10, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 15; k++) vecs.push_back(mk(1, 1, 0, 0, 1, 0, k == 9, (k < 9) ? k + 1 : 9, k >= 9));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 9, 1));
      vecs.push_back(mk(0, 1, 0, 1, 0, 3, 0, 3, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 5, 0, 5, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 7, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 7, 0, 7, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6, 0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 10, 0, 9, 0));
      vecs.push_back(mk(1, 1, 0, 1, 0, 9, 0, 9, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
`else
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 40; k++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, k == 39, ((k + 1) / 4) % 10, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0));
`endif
      foreach (vecs[i]) run_vec(vecs[i], i);

`ifndef PARAM_COUNTER_PRESCALE_EN
      // Asynchronous reset between edges at cnt=6.
      run_vec(mk(0, 1, 0, 1, 0, 6, 0, 6, 0), 900);
      #1 rst = 1'b1;
      #1;
      check("arst_mid_cnt", int'(cnt), 0);
      check("arst_mid_done", int'(done), 0);
      #1 rst = 1'b0;
      run_vec(mk(1, 1, 0, 0, 0, 0, 0, 1, 0), 901);

      // Asynchronous reset clears a sticky done.
      run_vec(mk(0, 1, 0, 1, 1, 8, 0, 8, 0), 902);
      run_vec(mk(1, 1, 0, 0, 1, 0, 0, 9, 0), 903);
      run_vec(mk(1, 1, 0, 0, 1, 0, 1, 9, 1), 904);
      #1 rst = 1'b1;
      #1;
      check("arst_done_cnt", int'(cnt), 0);
      check("arst_done_done", int'(done), 0);
      #1 rst = 1'b0;
`endif

      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         clr      = (i == 0) || ($urandom_range(0, 15) == 0);
         load     = ($urandom_range(0, 9) == 0);
         load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
         en       = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) up_dn = ~up_dn;
         if ($urandom_range(0, 24) == 0) oneshot = ~oneshot;
         #1;
         model_cycle(exp_tc);
         check($sformatf("rand%0d_tc", i), int'(tc), int'(exp_tc));
         @(posedge clk);
         #1;
         check($sformatf("rand%0d_cnt", i), int'(cnt), m_cnt);
         check($sformatf("rand%0d_done", i), int'(done), int'(m_done));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the team's 8-bit free-running counter.
- Width and modulus are configurable.
- Adds enable, up/down direction, synchronous clear and parallel load.
- Adds a terminal-count pulse and a one-shot (stop-at-terminal) mode with a sticky done flag.
- Used as the general-purpose event/timebase counter in lab designs; drives displays, timers and FSM timeouts.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MODULO, 256, count range 0..MODULO-1; must satisfy 2 <= MODULO <= 2**WIDTH.
- PRESCALE, 4, enable divide ratio (>=1); used only when PARAM_COUNTER_PRESCALE_EN is defined.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, count enable.
- up_dn, input, 1, 1 = count up, 0 = count down.
- clr, input, 1, synchronous clear.
- load, input, 1, synchronous parallel load.
- load_val, input, WIDTH, value to load.
- oneshot, input, 1, 1 = stop at terminal value, 0 = wrap.
- cnt, output, WIDTH, current count (registered).
- tc, output, 1, terminal-count pulse (combinational from registered state and inputs).
- done, output, 1, sticky one-shot completion flag (registered).

Behaviour:
- Clock and reset: single clock domain, clk; rst is asynchronous, active-high.
- Reset values: cnt=0, done=0, prescaler=0; tc=0 while rst=1.
- Priority per rising edge: rst > clr > load > count step > hold.
- clr=1: cnt<=0, done<=0, prescaler<=0.
- load=1 (clr=0): cnt<=load_val, done<=0, prescaler<=0.
  - If load_val >= MODULO, cnt<=MODULO-1 (clamp).
- Step condition: "step" = en=1 and not done (and prescaler at terminal, when the feature is enabled).
- Terminal value: T = MODULO-1 when up_dn=1; T = 0 when up_dn=0.
- Step with cnt != T: cnt<=cnt+1 (up) or cnt-1 (down).
- Step with cnt == T and oneshot=0: wrap; up gives cnt<=0, down gives cnt<=MODULO-1.
- Step with cnt == T and oneshot=1: cnt holds at T, done<=1.
- tc = step and cnt == T and clr=0 and load=0.
  - Exactly one cycle wide per terminal event.
  - Asserted on the wrap cycle or on the cycle done sets.
- done stays 1 until clr, load or rst.
  - While done=1, en has no effect and tc=0.
- Direction change mid-count: takes effect on the next step; no other side effects.
- Changing oneshot while done=1 does not clear done.
- Arithmetic is modulo MODULO, never modulo 2**WIDTH (matters when MODULO < 2**WIDTH).
- Latency: cnt updates one cycle after the qualifying edge; no pipeline.
- Reset mid-operation: immediate return to reset values regardless of clk.

Optional Feature:
- Macro: PARAM_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler counts en cycles 0..PRESCALE-1.
  - Step occurs only on the en cycle where the prescaler == PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler does not advance while done=1.
  - clr, load and rst zero the prescaler.
- Undefined: every en cycle is a step; PRESCALE is ignored and no prescaler logic is generated.

Decomposition:
- Package param_counter_pkg holds:
  - MAX_WIDTH=32.
  - Direction constants DIR_UP=1 and DIR_DOWN=0.
  - A function computing the terminal value from direction and MODULO.
- Sub-module counter_prescaler (en in, clr in, tick out), instantiated only under PARAM_COUNTER_PRESCALE_EN.
- Core counter and done/tc logic stay in param_counter.

Test Plan (WIDTH=8, MODULO=10, feature off unless stated):
- Reset/up-wrap: assert rst asynchronously, then release; en=1, up_dn=1, oneshot=0 for 12 cycles -> cnt 0,1,...,9,0,1; tc high only on the cycle cnt==9; cnt=0 while rst is held.
- Down-wrap and load clamp: load=1, load_val=200 -> cnt=9; then en=1, up_dn=0 for 11 cycles -> 8,...,0,9,8; tc high when cnt==0.
- One-shot: clr, then oneshot=1, up_dn=1, en=1 for 15 cycles -> cnt stops at 9; done=1 from cycle 10 on; tc pulses once; a later load_val=3 gives cnt=3, done=0.
- Priority: clr=1, load=1, en=1 in the same cycle with cnt=5 -> cnt=0.
  - Then load=1, en=1 with load_val=7 -> cnt=7; no step applied that cycle.
- Async reset mid-count: at cnt=6, pulse rst between clock edges -> cnt=0 and done=0 immediately, before the next clk edge.
- Prescale (PARAM_COUNTER_PRESCALE_EN, PRESCALE=4): en=1 for 40 cycles -> cnt increments every 4th cycle, reaches 9 then wraps to 0 at cycle 40; toggling en low freezes the prescaler phase.
